// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, NOP word
// and the register-field positions the hazard unit reads out of IF/ID.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_FETCH    = 2'd0,
        ST_BUFFERED = 2'd1,
        ST_DISCARD  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP = 32'h0000_0000;

    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;

    function automatic logic [4:0] instr_rs(input logic [31:0] instr);
        return instr[RS_HI:RS_LO];
    endfunction

    function automatic logic [4:0] instr_rt(input logic [31:0] instr);
        return instr[RT_HI:RT_LO];
    endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register. A bubble (flush or empty fetch) wins over a load
// and leaves PC+4 untouched, since only Valid and the instruction matter to ID.
module if_id_register
    import fetch_stage_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        i_load,
    input  logic        i_bubble,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pcplus4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pcplus4,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pcplus4;
    logic        r_valid;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_instr   <= NOP;
            r_pcplus4 <= 32'd0;
            r_valid   <= 1'b0;
        end else if (i_bubble) begin
            r_instr   <= NOP;
            r_valid   <= 1'b0;
        end else if (i_load) begin
            r_instr   <= i_instr;
            r_pcplus4 <= i_pcplus4;
            r_valid   <= 1'b1;
        end
    end

    assign o_instr   = r_instr;
    assign o_pcplus4 = r_pcplus4;
    assign o_valid   = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, one-entry response buffer for stalls, and the
// FETCH/BUFFERED/DISCARD control FSM feeding the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        PC_en,
    input  logic        IF_ID_en,
    input  logic        IF_ID_Flush,
    input  logic [31:0] BranchTarget,
    output logic        Imem_Req,
    output logic [31:0] Imem_Addr,
    input  logic        Imem_Ready,
    input  logic [31:0] Imem_Data,
    output logic [31:0] IF_ID_Instr,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid,
    output logic [4:0]  IF_ID_Rs,
    output logic [4:0]  IF_ID_Rt,
    output logic [1:0]  o_dbg_state
);

    // Memory handshake: a request is open while Imem_Req=1 with Imem_Addr
    // held; it completes on the first Clk edge that samples Imem_Ready=1.

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [31:0] r_pc;
    logic [31:0] r_buf_instr;
    logic [31:0] r_buf_pcplus4;
    logic [31:0] r_old_addr;
    logic        r_started;

    logic        w_advance;
    logic [31:0] w_pcplus4;
    logic        w_req_active;
    logic [31:0] w_pc_next;
    logic        w_ifid_load;
    logic        w_ifid_bubble;
    logic [31:0] w_ifid_instr;
    logic [31:0] w_ifid_pcplus4;
    logic        w_buf_capture;
    logic        w_old_capture;

    assign w_advance    = PC_en & IF_ID_en;
    assign w_pcplus4    = r_pc + 32'd4;
    // r_started keeps the request low until the first edge after reset release.
    assign w_req_active = r_started & (r_state != ST_BUFFERED);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_ifid_load    = 1'b0;
        w_ifid_bubble  = 1'b0;
        w_ifid_instr   = Imem_Data;
        w_ifid_pcplus4 = w_pcplus4;
        w_buf_capture  = 1'b0;
        w_old_capture  = 1'b0;

        if (IF_ID_Flush) begin
            w_pc_next     = {BranchTarget[31:2], 2'b00};
            w_ifid_bubble = 1'b1;
            case (r_state)
                ST_FETCH: begin
                    if (w_req_active && !Imem_Ready) begin
                        w_state_next  = ST_DISCARD;
                        w_old_capture = 1'b1;
                    end else begin
                        w_state_next = ST_FETCH;
                    end
                end
                ST_DISCARD: w_state_next = Imem_Ready ? ST_FETCH : ST_DISCARD;
                default:    w_state_next = ST_FETCH;
            endcase
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (w_req_active) begin
                        if (Imem_Ready && w_advance) begin
                            w_ifid_load = 1'b1;
                            w_pc_next   = w_pcplus4;
                        end else if (Imem_Ready) begin
                            w_buf_capture = 1'b1;
                            w_state_next  = ST_BUFFERED;
                        end else if (IF_ID_en) begin
                            w_ifid_bubble = 1'b1;
                        end
                    end
                end
                ST_BUFFERED: begin
                    if (w_advance) begin
                        w_ifid_load    = 1'b1;
                        w_ifid_instr   = r_buf_instr;
                        w_ifid_pcplus4 = r_buf_pcplus4;
                        w_pc_next      = w_pcplus4;
                        w_state_next   = ST_FETCH;
                    end
                end
                ST_DISCARD: begin
                    if (Imem_Ready) begin
                        w_state_next = ST_FETCH;
                    end
                end
                default: w_state_next = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_pc          <= RESET_PC;
            r_buf_instr   <= NOP;
            r_buf_pcplus4 <= 32'd0;
            r_old_addr    <= RESET_PC;
            r_started     <= 1'b0;
        end else begin
            r_pc      <= w_pc_next;
            r_started <= 1'b1;
            if (w_buf_capture) begin
                r_buf_instr   <= Imem_Data;
                r_buf_pcplus4 <= w_pcplus4;
            end
            if (w_old_capture) begin
                r_old_addr <= r_pc;
            end
        end
    end

    if_id_register u_if_id (
        .Clk       (Clk),
        .Reset     (Reset),
        .i_load    (w_ifid_load),
        .i_bubble  (w_ifid_bubble),
        .i_instr   (w_ifid_instr),
        .i_pcplus4 (w_ifid_pcplus4),
        .o_instr   (IF_ID_Instr),
        .o_pcplus4 (IF_ID_PCPlus4),
        .o_valid   (IF_ID_Valid)
    );

    assign Imem_Req    = w_req_active;
    // During DISCARD the abandoned request must keep its original address.
    assign Imem_Addr   = (r_state == ST_DISCARD) ? r_old_addr : r_pc;
    assign IF_ID_Rs    = instr_rs(IF_ID_Instr);
    assign IF_ID_Rt    = instr_rt(IF_ID_Instr);
    assign o_dbg_state = r_state;

endmodule
